// File: rtl/act_lut_loader.sv
// Activation-LUT writer: streams one table of LUT_DEPTH {A,B} entries into the LUT BRAM port.
// Optional ACT_LUT_LOADER_CHECKSUM_EN adds a trailing checksum word verified in state CHK.
module act_lut_loader #(
    parameter int LUT_WIDTH  = 24,
    parameter int ADDR_WIDTH = 4,
    parameter int LUT_DEPTH  = 16,
    parameter int IN_WIDTH   = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_coe_vld,
    input  logic [IN_WIDTH-1:0]   i_coe_dat,
    output logic                  o_coe_rdy,
    output logic [LUT_WIDTH-1:0]  o_lut_bramctl_wdata,
    output logic [ADDR_WIDTH-1:0] o_lut_bramctl_addr,
    output logic                  o_lut_bramctl_we,
    output logic                  o_lut_bramctl_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    // state | meaning
    // IDLE  | waiting for i_start
    // LOAD  | accepting table words, one LUT write per accept
    // CHK   | accepting the checksum word (checksum builds only)
    // FIN   | one cycle before the o_done pulse
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LUT_DEPTH - 1);
    localparam logic [WD_W-1:0]       WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FIN  = 2'd2
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
        , S_CHK = 2'd3
`endif
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
    logic [WD_W-1:0]        wd_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LUT_WIDTH-1:0]   wdata_q;
    logic                   done_q;
    logic                   err_q;
    logic                   upper_nz;
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
    logic [LUT_WIDTH-1:0]   sum_q;
`endif

    assign upper_nz = (i_coe_dat >> LUT_WIDTH) != '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_LOAD;
                        cnt_q   <= '0;
                        wd_q    <= '0;
                        err_q   <= 1'b0;
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    // abort wins over a same-cycle accept: the word is consumed but dropped
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (i_coe_vld) begin
                        we_q    <= 1'b1;
                        addr_q  <= cnt_q;
                        wdata_q <= i_coe_dat[LUT_WIDTH-1:0];
                        cnt_q   <= cnt_q + 1'b1;
                        wd_q    <= '0;
                        if (upper_nz) err_q <= 1'b1;
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + i_coe_dat[LUT_WIDTH-1:0];
                        if (cnt_q == LAST_ADDR) state_q <= S_CHK;
`else
                        if (cnt_q == LAST_ADDR) state_q <= S_FIN;
`endif
                    end else if (wd_q == WD_LAST) begin
                        state_q <= S_FIN;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (i_abort) begin
                        state_q <= S_IDLE;
                    end else if (i_coe_vld) begin
                        if (i_coe_dat[LUT_WIDTH-1:0] != sum_q) err_q <= 1'b1;
                        state_q <= S_FIN;
                    end else if (wd_q == WD_LAST) begin
                        state_q <= S_FIN;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
`endif
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ACT_LUT_LOADER_CHECKSUM_EN
    assign o_coe_rdy = (state_q == S_LOAD) || (state_q == S_CHK);
`else
    assign o_coe_rdy = (state_q == S_LOAD);
`endif
    assign o_busy              = (state_q != S_IDLE);
    assign o_lut_bramctl_we    = we_q;
    assign o_lut_bramctl_en    = we_q;
    assign o_lut_bramctl_addr  = addr_q;
    assign o_lut_bramctl_wdata = wdata_q;
    assign o_done              = done_q;
    assign o_err               = err_q;
endmodule

// File: tb/tb_act_lut_loader.sv
// Scoreboard bench for act_lut_loader: expected writes/done events queued at issue, checked by a monitor.
module tb_act_lut_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        coe_vld = 1'b0;
    logic [31:0] coe_dat = '0;
    logic        coe_rdy;
    logic [23:0] wdata;
    logic [3:0]  addr;
    logic        we, en, busy, done, err;

    act_lut_loader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_coe_vld(coe_vld), .i_coe_dat(coe_dat), .o_coe_rdy(coe_rdy),
        .o_lut_bramctl_wdata(wdata), .o_lut_bramctl_addr(addr),
        .o_lut_bramctl_we(we), .o_lut_bramctl_en(en),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

`ifdef ACT_LUT_LOADER_CHECKSUM_EN
    localparam bit ADJ = 1'b0;
`else
    localparam bit ADJ = 1'b1;
`endif

    typedef struct { logic [3:0] a; logic [23:0] d; } wr_t;
    typedef struct { logic e; bit adj; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastwr = -100;
    int nwr = 0;
    int ndone = 0;
    logic [3:0]  nxt_addr = '0;
    logic [23:0] sum = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we || en) begin
                check("en_eq_we", {31'd0, en}, {31'd0, we});
                if (we) begin
                    nwr++;
                    if (wq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_write addr=%h data=%h", addr, wdata);
                    end else begin
                        wr_t e;
                        e = wq.pop_front();
                        check("wr_addr", {28'd0, addr}, {28'd0, e.a});
                        check("wr_data", {8'd0, wdata}, {8'd0, e.d});
                    end
                    if (addr == 4'hF) lastwr = cyc;
                end
            end
            if (done) begin
                ndone++;
                if (dq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done err=%b", err);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    check("done_err", {31'd0, err}, {31'd0, d.e});
                    if (d.adj) check("done_latency", cyc, lastwr + 1);
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nxt_addr = '0;
        sum = '0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Present a word and hold vld until accepted; leaves vld high on return.
    task automatic push(input logic [31:0] d, input bit wr);
        bit ok;
        ok = 1'b0;
        coe_vld = 1'b1;
        coe_dat = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (coe_rdy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL push_timeout word=%h", d);
        end else begin
            if (wr) begin
                wq.push_back('{a: nxt_addr, d: d[23:0]});
                nxt_addr = nxt_addr + 1'b1;
                sum = sum + d[23:0];
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        coe_vld = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tail(input logic [23:0] delta);
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
        logic [23:0] c;
        c = sum + delta;
        push({8'd0, c}, 1'b0);
`else
        if (delta != 24'd0) $display("note: checksum delta ignored in this build");
`endif
        coe_vld = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n0;
        bit ok;
        n0 = ndone;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #2;
            if (ndone != n0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_done_timeout limit=%0d", lim);
        end
    endtask

    initial begin
        int n0;
        #3;
        check("rst_rdy", {31'd0, coe_rdy}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr_data", {4'd0, addr, wdata}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // back-to-back load
        do_start();
        dq.push_back('{e: 1'b0, adj: ADJ});
        for (int i = 0; i < 16; i++) push(i, 1'b1);
`ifndef ACT_LUT_LOADER_CHECKSUM_EN
        check("rdy_low_after_last_b2b", {31'd0, coe_rdy}, 32'd0);
`endif
        tail(24'd0);
        wait_done(20);
        idle(2);

        // source stalls 1,0,0
        do_start();
        dq.push_back('{e: 1'b0, adj: ADJ});
        for (int i = 0; i < 16; i++) begin
            push(32'h20 + i, 1'b1);
            if (i == 15) begin
`ifndef ACT_LUT_LOADER_CHECKSUM_EN
                check("rdy_low_after_last_stall", {31'd0, coe_rdy}, 32'd0);
`endif
            end else begin
                idle(2);
            end
        end
        tail(24'd0);
        wait_done(20);
        idle(3);

        // stall timeout after 5 words
        do_start();
        dq.push_back('{e: 1'b1, adj: 1'b0});
        for (int i = 0; i < 5; i++) push(32'h30 + i, 1'b1);
        idle(0);
        wait_done(1100);
        check("err_held_after_timeout", {31'd0, err}, 32'd1);
        do_start();
        check("start_clears_err", {31'd0, err}, 32'd0);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        idle(2);

        // abort on the 8th accept
        do_start();
        for (int i = 0; i < 7; i++) push(32'h50 + i, 1'b1);
        n0 = ndone;
        coe_dat = 32'h57;
        abort = 1'b1;
        @(negedge clk);
        check("rdy_at_abort", {31'd0, coe_rdy}, 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        coe_vld = 1'b0;
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        idle(4);
        check("no_done_after_abort", ndone, n0);
        check("err_kept_on_abort", {31'd0, err}, 32'd0);
        do_start();
        dq.push_back('{e: 1'b0, adj: ADJ});
        for (int i = 0; i < 16; i++) push(32'h300 + i, 1'b1);
        tail(24'd0);
        wait_done(20);
        idle(2);

        // non-zero upper bits on 3rd word
        do_start();
        dq.push_back('{e: 1'b1, adj: ADJ});
        for (int i = 0; i < 16; i++) push((i == 2) ? 32'h01ABCDEF : 32'h40 + i, 1'b1);
        tail(24'd0);
        wait_done(20);
        idle(2);

`ifdef ACT_LUT_LOADER_CHECKSUM_EN
        // checksum good (0x88) then bad (0x89)
        do_start();
        dq.push_back('{e: 1'b0, adj: 1'b0});
        for (int i = 1; i <= 16; i++) push(i, 1'b1);
        check("model_sum", {8'd0, sum}, 32'h88);
        tail(24'd0);
        wait_done(20);
        idle(2);
        do_start();
        dq.push_back('{e: 1'b1, adj: 1'b0});
        for (int i = 1; i <= 16; i++) push(i, 1'b1);
        tail(24'd1);
        wait_done(20);
        idle(2);
`endif

        // async reset kills an in-flight write strobe
        do_start();
        push(32'h55, 1'b0);
        coe_vld = 1'b0;
        check("we_before_reset", {31'd0, we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("we_killed_by_reset", {31'd0, we}, 32'd0);
        check("en_killed_by_reset", {31'd0, en}, 32'd0);
        check("busy_killed_by_reset", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;
        idle(3);

        check("wq_drained", wq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
`ifdef ACT_LUT_LOADER_CHECKSUM_EN
        check("total_writes", nwr, 32'd108);
`else
        check("total_writes", nwr, 32'd76);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/act_lut_loader.md
Name: act_lut_loader

Overview:
- Writer side of the activation-LUT BRAM control port.
- Accepts a valid/ready stream of coefficient words from the config/DMA path and writes one full table of LUT_DEPTH entries into the activation LUT through the wdata/addr/we/en port.
- Each 24-bit entry packs an 8-bit slope A and a 16-bit offset B, matching the linear activation stage.
- Sequenced by a start/done handshake from the layer controller. A per-word watchdog flags a stalled source.

Parameters:
- LUT_WIDTH, 24: LUT entry width, {A[7:0], B[15:0]}.
- ADDR_WIDTH, 4: LUT address width.
- LUT_DEPTH, 16: number of entries per table load; must be ≤ 2^ADDR_WIDTH.
- IN_WIDTH, 32: input stream word width. Bits [LUT_WIDTH-1:0] carry the entry; the upper bits must be zero.
- TIMEOUT, 1024: LOAD-state cycles allowed without an accepted word before error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_start  in  1  start a table load; sampled only in IDLE
- i_abort  in  1  cancel a load in progress
- i_coe_vld  in  1  stream word valid
- i_coe_dat  in  IN_WIDTH  stream word
- o_coe_rdy  out  1  stream ready
- o_lut_bramctl_wdata  out  LUT_WIDTH  LUT write data
- o_lut_bramctl_addr  out  ADDR_WIDTH  LUT write address
- o_lut_bramctl_we  out  1  LUT write strobe
- o_lut_bramctl_en  out  1  LUT enable
- o_busy  out  1  load in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error flag

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter 0; watchdog 0.
- FSM states: IDLE, LOAD, CHK (macro builds only), FIN.
- IDLE
  - o_coe_rdy=0, o_busy=0.
  - i_start=1 → LOAD. Clears the counter, watchdog and o_err.
- LOAD
  - o_coe_rdy=1 and o_busy=1, both decoded from the registered state with no combinational path from i_coe_vld.
  - On accept (vld & rdy) at cycle T: at T+1, we=en=1 for exactly one cycle, addr=counter value at T, wdata=i_coe_dat[LUT_WIDTH-1:0].
  - The counter increments on each accept. Back-to-back accepts give one write per cycle.
  - If i_coe_dat[IN_WIDTH-1:LUT_WIDTH] ≠ 0, the entry is still written and o_err is set.
  - The accept with counter=LUT_DEPTH-1 moves the FSM to FIN, or to CHK if the macro is defined. o_coe_rdy drops at T+1, so a word presented at T+1 is not accepted.
  - The watchdog counts LOAD cycles without an accept and resets on each accept. Reaching TIMEOUT → FIN with o_err=1. Entries already written remain valid.
- FIN
  - o_done=1 for one cycle, then IDLE. o_busy stays 1 through FIN.
  - o_done therefore lands one cycle after the last write strobe.
- i_abort
  - In LOAD or CHK: goes to IDLE next cycle with no o_done and o_err unchanged.
  - A write strobe already registered for the current cycle still completes.
  - Ignored in IDLE and FIN.
  - If i_abort and an accept occur in the same cycle, abort wins: o_coe_rdy is 1 so the word is consumed, but it is not written.
- i_start while busy: ignored.
- i_start in the FIN cycle: ignored. The controller must wait for o_done.
- o_lut_bramctl_en is never asserted without we; this block performs no reads.
- Reset mid-load: asynchronous return to IDLE; any write strobe is killed immediately.

Optional Feature:
- Macro: ACT_LUT_LOADER_CHECKSUM_EN.
- Defined:
  - After LUT_DEPTH entries the FSM enters CHK with o_coe_rdy=1 and accepts one extra word.
  - That word's [LUT_WIDTH-1:0] is compared against the running sum of written entries mod 2^LUT_WIDTH. Mismatch → o_err=1.
  - No LUT write occurs for the checksum word. CHK → FIN on accept.
  - The watchdog also applies in CHK.
- Not defined:
  - The CHK state and summing logic are absent; loads are exactly LUT_DEPTH words.

Test Plan:
- Back-to-back load: i_start, then 16 words 0x00000000..0x0000000F with vld held high → we on 16 consecutive cycles, addr 0..15, wdata equal to the word, o_done one cycle after the addr=15 write, o_err=0.
- Source stalls: vld toggled 1,0,0,1,… with 16 words → writes only on accepted words, addresses contiguous 0..15, exactly one o_done, rdy low after the 16th accept.
- Stall timeout: 5 words then vld=0 for 1024 cycles → 5 writes (addr 0..4), then o_done=1 with o_err=1; the next i_start clears o_err.
- Abort mid-load: abort asserted on the same cycle as the 8th accept → 7 writes only, no o_done, o_busy=0 the next cycle; a following i_start restarts at addr 0.
- Bad upper bits: 3rd word 0x01ABCDEF → addr 2 written with 0xABCDEF, o_err=1 at o_done.
- Checksum (macro on): entries 1..16, then checksum 0x000088 → o_err=0; rerun with checksum 0x000089 → o_err=1; exactly 16 writes in both runs.
